// File: rtl/diag_ebus_reader_if.sv
// Request/response handshake bundle between the diagnostic console logic and diag_ebus_reader.
// The reader uses the slave modport; the console side uses master.
interface diag_ebus_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sel;
    logic        req_burst;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:35] rsp_data;
    logic [2:0]  rsp_sel;
    logic        rsp_last;

    modport master (
        output req_valid, req_sel, req_burst, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_sel, rsp_last
    );

    modport slave (
        input  req_valid, req_sel, req_burst, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_sel, rsp_last
    );
endinterface

// File: rtl/diag_ebus_reader.sv
// Diagnostic-side EBUS reader: drives a DIAG select plus read strobe toward SCD and waits the settle time.
// It then latches the 36-bit EBUS word and hands it out on a valid/ready response, optionally walking DIAG up to 7.
module diag_ebus_reader #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    diag_ebus_reader_if.slave    bus,
    input  logic                 abort,
    output logic [4:6]           DIAG,
    output logic                 DIAG_READ_FUNC_13X,
    input  logic [0:35]          EBUS,
    output logic                 busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_r;
    logic [2:0]  diag_r;
    logic        strobe_r;
    logic [3:0]  cnt_r;
    logic        burst_r;
    logic        busy_r;
    logic        rsp_valid_r;
    logic [0:35] rsp_data_r;
    logic [2:0]  rsp_sel_r;
    logic        rsp_last_r;

    assign DIAG               = diag_r;
    assign DIAG_READ_FUNC_13X = strobe_r;
    assign busy               = busy_r;
    assign bus.req_ready      = (state_r == IDLE);
    assign bus.rsp_valid      = rsp_valid_r;
    assign bus.rsp_data       = rsp_data_r;
    assign bus.rsp_sel        = rsp_sel_r;
    assign bus.rsp_last       = rsp_last_r;

    // Read sequencer: the strobe and every response field are registered so SCD and the consumer see clean levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            diag_r      <= 3'd0;
            strobe_r    <= 1'b0;
            cnt_r       <= 4'd0;
            burst_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 36'd0;
            rsp_sel_r   <= 3'd0;
            rsp_last_r  <= 1'b0;
        end else if (abort) begin
            // Abort beats a same-cycle rsp_ready: the pending word is simply dropped.
            state_r     <= IDLE;
            strobe_r    <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        diag_r   <= bus.req_sel;
                        burst_r  <= bus.req_burst;
                        cnt_r    <= CNT_INIT;
                        strobe_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= DRIVE;
                    end else begin
                        strobe_r <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data_r  <= EBUS;
                        rsp_sel_r   <= diag_r;
                        rsp_last_r  <= ~burst_r | (diag_r == 3'd7);
                        rsp_valid_r <= 1'b1;
                        strobe_r    <= 1'b0;
                        state_r     <= HOLD;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                HOLD: begin
                    // The strobe is low here, so stepping DIAG on the accept edge never moves it under a live strobe.
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (rsp_last_r) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            diag_r   <= diag_r + 3'd1;
                            cnt_r    <= CNT_INIT;
                            strobe_r <= 1'b1;
                            state_r  <= DRIVE;
                        end
                    end else begin
                        strobe_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    strobe_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_ebus_reader.sv
// Directed bench for diag_ebus_reader: table of read requests with hand-computed responses,
// plus hand sequences for backpressure, abort and mid-read reset.
module tb_diag_ebus_reader;

    localparam int SETTLE = 2;

    typedef struct {
        logic [2:0]  sel;
        logic        burst;
        logic        reflect;
        logic [35:0] ebus;
        int          words;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        abort;
    logic [4:6]  DIAG;
    logic        DIAG_READ_FUNC_13X;
    logic [0:35] ebus;
    logic        busy;
    logic        reflect;
    logic [35:0] ebus_const;

    int checks = 0;
    int errors = 0;
    vec_t vecs [6];

    diag_ebus_reader_if bus_if ();

    diag_ebus_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus_if),
        .abort              (abort),
        .DIAG               (DIAG),
        .DIAG_READ_FUNC_13X (DIAG_READ_FUNC_13X),
        .EBUS               (ebus),
        .busy               (busy)
    );

    // EBUS source: either a fixed word or the current select reflected back.
    assign ebus = reflect ? {33'd0, DIAG} : ebus_const;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (bus_if.rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, 64'(bus_if.rsp_valid), 64'd1);
    endtask

    task automatic issue(input logic [2:0] sel, input logic burst);
        bus_if.req_valid = 1'b1;
        bus_if.req_sel   = sel;
        bus_if.req_burst = burst;
        step();
        bus_if.req_valid = 1'b0;
    endtask

    // Cycle-exact run of one request: strobe high SETTLE cycles, then one HOLD cycle per word.
    task automatic run_vec(input vec_t v, input int idx);
        logic [2:0]  exp_sel;
        logic [35:0] exp_data;
        exp_sel = v.sel;
        chk($sformatf("v%0d_idle_ready", idx), 64'(bus_if.req_ready), 64'd1);
        chk($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
        reflect    = v.reflect;
        ebus_const = v.ebus;
        issue(v.sel, v.burst);
        for (int k = 0; k < v.words; k++) begin
            exp_sel  = v.sel + 3'(k);
            exp_data = v.reflect ? {33'd0, exp_sel} : v.ebus;
            for (int c = 0; c < SETTLE; c++) begin
                chk($sformatf("v%0d_w%0d_strobe_hi", idx, k), 64'(DIAG_READ_FUNC_13X), 64'd1);
                chk($sformatf("v%0d_w%0d_diag", idx, k), 64'(DIAG), 64'(exp_sel));
                chk($sformatf("v%0d_w%0d_no_rsp", idx, k), 64'(bus_if.rsp_valid), 64'd0);
                step();
            end
            chk($sformatf("v%0d_w%0d_strobe_lo", idx, k), 64'(DIAG_READ_FUNC_13X), 64'd0);
            chk($sformatf("v%0d_w%0d_rsp_valid", idx, k), 64'(bus_if.rsp_valid), 64'd1);
            chk($sformatf("v%0d_w%0d_rsp_data", idx, k), 64'(bus_if.rsp_data), 64'(exp_data));
            chk($sformatf("v%0d_w%0d_rsp_sel", idx, k), 64'(bus_if.rsp_sel), 64'(exp_sel));
            chk($sformatf("v%0d_w%0d_rsp_last", idx, k), 64'(bus_if.rsp_last), 64'(k == v.words - 1));
            bus_if.rsp_ready = 1'b1;
            step();
            bus_if.rsp_ready = 1'b0;
        end
        chk($sformatf("v%0d_done_valid", idx), 64'(bus_if.rsp_valid), 64'd0);
        chk($sformatf("v%0d_done_busy", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d_done_ready", idx), 64'(bus_if.req_ready), 64'd1);
        chk($sformatf("v%0d_done_diag", idx), 64'(DIAG), 64'(exp_sel));
    endtask

    initial begin
        vecs[0] = '{sel: 3'd3, burst: 1'b0, reflect: 1'b0, ebus: 36'o123456701234, words: 1};
        vecs[1] = '{sel: 3'd0, burst: 1'b0, reflect: 1'b0, ebus: 36'o777777777777, words: 1};
        vecs[2] = '{sel: 3'd5, burst: 1'b1, reflect: 1'b1, ebus: 36'o0,            words: 3};
        vecs[3] = '{sel: 3'd7, burst: 1'b1, reflect: 1'b1, ebus: 36'o0,            words: 1};
        vecs[4] = '{sel: 3'd6, burst: 1'b1, reflect: 1'b0, ebus: 36'o000000000001, words: 2};
        vecs[5] = '{sel: 3'd7, burst: 1'b0, reflect: 1'b0, ebus: 36'o525252525252, words: 1};

        reset            = 1'b1;
        abort            = 1'b0;
        reflect          = 1'b0;
        ebus_const       = 36'd0;
        bus_if.req_valid = 1'b0;
        bus_if.req_sel   = 3'd0;
        bus_if.req_burst = 1'b0;
        bus_if.rsp_ready = 1'b0;
        step();
        step();
        chk("rst_diag", 64'(DIAG), 64'd0);
        chk("rst_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
        chk("rst_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        chk("rst_ready", 64'(bus_if.req_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: response must hold while EBUS moves and the consumer stalls.
        reflect    = 1'b0;
        ebus_const = 36'o111122223333;
        issue(3'd2, 1'b0);
        wait_rsp("bp_wait");
        for (int i = 0; i < 10; i++) begin
            ebus_const = 36'o111122223333 + 36'(i + 1);
            step();
            chk("bp_data", 64'(bus_if.rsp_data), 64'o111122223333);
            chk("bp_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
            chk("bp_valid", 64'(bus_if.rsp_valid), 64'd1);
        end
        bus_if.rsp_ready = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        chk("bp_accept_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("bp_accept_busy", 64'(busy), 64'd0);

        // Abort in DRIVE of a burst from 0.
        issue(3'd0, 1'b1);
        chk("abd_strobe_pre", 64'(DIAG_READ_FUNC_13X), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abd_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
        chk("abd_busy", 64'(busy), 64'd0);
        chk("abd_ready", 64'(bus_if.req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("abd_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
            step();
        end
        run_vec(vecs[0], 10);

        // Abort in HOLD wins over a same-cycle accept of a non-last burst word.
        issue(3'd1, 1'b1);
        wait_rsp("abh_wait");
        bus_if.rsp_ready = 1'b1;
        abort            = 1'b1;
        step();
        bus_if.rsp_ready = 1'b0;
        abort            = 1'b0;
        chk("abh_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("abh_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
        chk("abh_busy", 64'(busy), 64'd0);

        // Abort together with req_valid in IDLE: request ignored.
        bus_if.req_valid = 1'b1;
        bus_if.req_sel   = 3'd4;
        bus_if.req_burst = 1'b0;
        abort            = 1'b1;
        step();
        bus_if.req_valid = 1'b0;
        abort            = 1'b0;
        chk("abi_busy", 64'(busy), 64'd0);
        chk("abi_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
        step();
        chk("abi_busy2", 64'(busy), 64'd0);

        // Reset in HOLD with rsp_ready high in the same cycle.
        reflect = 1'b1;
        issue(3'd4, 1'b1);
        wait_rsp("rsh_wait");
        bus_if.rsp_ready = 1'b1;
        reset            = 1'b1;
        step();
        chk("rsh_diag", 64'(DIAG), 64'd0);
        chk("rsh_strobe", 64'(DIAG_READ_FUNC_13X), 64'd0);
        chk("rsh_valid", 64'(bus_if.rsp_valid), 64'd0);
        chk("rsh_data", 64'(bus_if.rsp_data), 64'd0);
        chk("rsh_sel", 64'(bus_if.rsp_sel), 64'd0);
        chk("rsh_last", 64'(bus_if.rsp_last), 64'd0);
        chk("rsh_busy", 64'(busy), 64'd0);
        chk("rsh_ready", 64'(bus_if.req_ready), 64'd1);
        reset            = 1'b0;
        bus_if.rsp_ready = 1'b0;
        step();
        chk("rsh_post_busy", 64'(busy), 64'd0);
        chk("rsh_post_valid", 64'(bus_if.rsp_valid), 64'd0);
        run_vec(vecs[2], 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
